// File: rtl/bcd_score_keeper_if.sv
// Hit/miss strobes in, packed-BCD score/high score out, between the game
// logic and the seven-segment digit decoders.
interface bcd_score_keeper_if #(
  parameter int DIGITS = 3
);
  logic                  enable;
  logic                  clear;
  logic                  hit_pulse;
  logic                  miss_pulse;
  logic [4*DIGITS-1:0]   score;
  logic [4*DIGITS-1:0]   high_score;
  logic [3:0]            mult;
  logic                  at_max;
  logic                  new_high;

  modport master (
    output enable, clear, hit_pulse, miss_pulse,
    input  score, high_score, mult, at_max, new_high
  );

  modport slave (
    input  enable, clear, hit_pulse, miss_pulse,
    output score, high_score, mult, at_max, new_high
  );
endinterface

// File: rtl/bcd_score_keeper.sv
// Packed-BCD score accumulator with a streak multiplier, a miss penalty,
// saturation at MAX_SCORE and a session high-score register.
module bcd_score_keeper #(
  parameter int DIGITS      = 3,
  parameter int MAX_SCORE   = 999,
  parameter int STREAK_STEP = 4,
  parameter int MULT_MAX    = 4,
  parameter int PENALTY     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_score_keeper_if.slave        io_bus
);

  localparam int W      = 4 * DIGITS;
  localparam int STEP_W = (STREAK_STEP > 1) ? $clog2(STREAK_STEP) : 1;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] bcd;
    int           v;
    bcd = '0;
    v   = value;
    for (int i = 0; i < DIGITS; i++) begin
      bcd[4*i +: 4] = 4'(v % 10);
      v             = v / 10;
    end
    return bcd;
  endfunction

  localparam logic [W-1:0]      MAX_BCD   = to_bcd(MAX_SCORE);
  localparam logic [3:0]        PEN       = 4'(PENALTY);
  localparam logic [3:0]        MULT_TOP  = 4'(MULT_MAX);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STREAK_STEP - 1);

  logic [W-1:0]      r_score;
  logic [W-1:0]      r_high;
  logic [3:0]        r_mult;
  logic [STEP_W-1:0] r_step;
  logic              r_at_max;
  logic              r_new_high;

  logic [W-1:0]      w_sum;
  logic [W-1:0]      w_diff;
  logic [DIGITS:0]   w_add_c;
  logic [DIGITS:0]   w_sub_b;

  logic [W-1:0]      w_score_next;
  logic [3:0]        w_mult_next;
  logic [STEP_W-1:0] w_step_next;
  logic              w_at_max_next;
  logic              w_hit;
  logic              w_miss;
  logic              w_sum_over;

  assign w_add_c[0] = 1'b0;
  assign w_sub_b[0] = 1'b0;

  // Per-digit decimal adder and subtractor; only digit 0 sees a non-zero operand.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] w_add_op;
    logic [3:0] w_sub_op;
    logic [4:0] w_dsum;
    logic [4:0] w_ddiff;

    assign w_add_op = (gi == 0) ? r_mult : 4'd0;
    assign w_sub_op = (gi == 0) ? PEN    : 4'd0;

    assign w_dsum         = {1'b0, r_score[4*gi +: 4]} + {1'b0, w_add_op}
                          + {4'd0, w_add_c[gi]};
    assign w_add_c[gi+1]  = (w_dsum > 5'd9);
    assign w_sum[4*gi +: 4] = w_add_c[gi+1] ? 4'(w_dsum - 5'd10) : w_dsum[3:0];

    assign w_ddiff        = {1'b0, r_score[4*gi +: 4]} - {1'b0, w_sub_op}
                          - {4'd0, w_sub_b[gi]};
    assign w_sub_b[gi+1]  = w_ddiff[4];
    assign w_diff[4*gi +: 4] = w_sub_b[gi+1] ? 4'(w_ddiff + 5'd10) : w_ddiff[3:0];
  end

  assign w_hit  = io_bus.enable & io_bus.hit_pulse;
  assign w_miss = io_bus.enable & io_bus.miss_pulse & ~io_bus.hit_pulse;

  // Valid packed BCD orders the same as its decimal value, so a plain
  // unsigned compare is a correct magnitude compare.
  assign w_sum_over = w_add_c[DIGITS] | (w_sum > MAX_BCD);

  always_comb begin
    w_score_next = r_score;
    w_mult_next  = r_mult;
    w_step_next  = r_step;
    if (io_bus.clear) begin
      w_score_next = '0;
      w_mult_next  = 4'd1;
      w_step_next  = '0;
    end else if (w_hit) begin
      w_score_next = w_sum_over ? MAX_BCD : w_sum;
      if (r_step == STEP_LAST) begin
        w_step_next = '0;
        if (r_mult < MULT_TOP) begin
          w_mult_next = r_mult + 4'd1;
        end
      end else begin
        w_step_next = r_step + STEP_W'(1);
      end
    end else if (w_miss) begin
      w_score_next = w_sub_b[DIGITS] ? '0 : w_diff;
      w_mult_next  = 4'd1;
      w_step_next  = '0;
    end
  end

  assign w_at_max_next = ~io_bus.clear & (w_score_next == MAX_BCD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score  <= '0;
      r_mult   <= 4'd1;
      r_step   <= '0;
      r_at_max <= 1'b0;
    end else begin
      r_score  <= w_score_next;
      r_mult   <= w_mult_next;
      r_step   <= w_step_next;
      r_at_max <= w_at_max_next;
    end
  end

  // High score tracks the registered score, so it trails by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high     <= '0;
      r_new_high <= 1'b0;
    end else if (r_score > r_high) begin
      r_high     <= r_score;
      r_new_high <= 1'b1;
    end else begin
      r_new_high <= 1'b0;
    end
  end

  assign io_bus.score      = r_score;
  assign io_bus.high_score = r_high;
  assign io_bus.mult       = r_mult;
  assign io_bus.at_max     = r_at_max;
  assign io_bus.new_high   = r_new_high;

endmodule
